regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 78 +++++++
 tb/tb_regfile_sb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file (r0 hardwired to zero) with a per-register pending-producer scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data onto rd1/rd2.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     a1,
    input  logic [AW-1:0]     a2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic              busy1,
    output logic              busy2,
    output logic [CW-1:0]     busy_cnt,
    input  logic [AW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic              wr_en;
    logic              iss_en;

    assign wr_en  = we && (wa != '0);
    assign iss_en = iss_valid && (iss_addr != '0);

    // Issue is applied after the write-clear so a new producer supersedes the old one;
    // flush overrides both.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) busy_nxt[wa] = 1'b0;
        if (iss_en) busy_nxt[iss_addr] = 1'b1;
        if (flush) busy_nxt = '0;
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_en) regs[wa] <= wd;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // r0 is never written, so a plain array read already returns zero for it.
`ifdef REGFILE_SB_BYPASS_EN
    assign rd1 = (rst_n && we && (wa == a1) && (a1 != '0)) ? wd : regs[a1];
    assign rd2 = (rst_n && we && (wa == a2) && (a2 != '0)) ? wd : regs[a2];
`else
    assign rd1 = regs[a1];
    assign rd2 = regs[a2];
`endif

    assign dbg_data = regs[dbg_sel];
    assign busy1    = busy[a1] && !(we && (wa == a1));
    assign busy2    = busy[a2] && !(we && (wa == a2));

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb: expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int CW     = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     a1, a2, wa, iss_addr, dbg_sel;
    logic [DATA_W-1:0] rd1, rd2, wd, dbg_data;
    logic              we, iss_valid, flush, busy1, busy2;
    logic [CW-1:0]     busy_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .flush(flush), .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle();
        a1 = 5'd5; a2 = 5'd7; dbg_sel = 5'd9;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #12;
        exp_v = exp_q.pop_front(); checks++;
        if ({26'h0, busy_cnt} !== exp_v) begin failures++; $display("[TB] FAIL reset_busy_cnt: got %0d expected %0d", busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin failures++; $display("[TB] FAIL reset_rd1: got %h expected %h", rd1, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (dbg_data !== exp_v) begin failures++; $display("[TB] FAIL reset_dbg: got %h expected %h", dbg_data, exp_v); end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
        tick();
        idle(); a1 = 5'd5; a2 = 5'd5; dbg_sel = 5'd5;
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin failures++; $display("[TB] FAIL write_rd1: got %h expected %h", rd1, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rd2 !== exp_v) begin failures++; $display("[TB] FAIL write_rd2: got %h expected %h", rd2, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (dbg_data !== exp_v) begin failures++; $display("[TB] FAIL write_dbg: got %h expected %h", dbg_data, exp_v); end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wa = 5'd0; wd = 32'h12345678;
        iss_valid = 1'b1; iss_addr = 5'd0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        tick();
        idle(); a1 = 5'd0; dbg_sel = 5'd0;
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin failures++; $display("[TB] FAIL zero_rd1: got %h expected %h", rd1, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({26'h0, busy_cnt} !== exp_v) begin failures++; $display("[TB] FAIL zero_busy_cnt: got %0d expected %0d", busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'h0, busy1} !== exp_v) begin failures++; $display("[TB] FAIL zero_busy1: got %0d expected %0d", busy1, exp_v); end
    endtask

    task automatic test_busy();
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        iss_addr = 5'd7;
        exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        tick();
        idle(); a1 = 5'd3; a2 = 5'd7;
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if ({26'h0, busy_cnt} !== exp_v) begin failures++; $display("[TB] FAIL busy_cnt_two: got %0d expected %0d", busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'h0, busy1} !== exp_v) begin failures++; $display("[TB] FAIL busy1_r3: got %0d expected %0d", busy1, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'h0, busy2} !== exp_v) begin failures++; $display("[TB] FAIL busy2_r7: got %0d expected %0d", busy2, exp_v); end
        // A write to r3 masks busy1 combinationally before the edge.
        we = 1'b1; wa = 5'd3; wd = 32'h33333333;
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if ({31'h0, busy1} !== exp_v) begin failures++; $display("[TB] FAIL busy1_masked: got %0d expected %0d", busy1, exp_v); end
        tick();
        idle();
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if ({26'h0, busy_cnt} !== exp_v) begin failures++; $display("[TB] FAIL busy_cnt_after_write: got %0d expected %0d", busy_cnt, exp_v); end
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        we = 1'b1; wa = 5'd3; wd = 32'h44444444; iss_valid = 1'b1; iss_addr = 5'd3;
        exp_q.push_back(32'd2); exp_q.push_back(32'd1);
        tick();
        idle();
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if ({26'h0, busy_cnt} !== exp_v) begin failures++; $display("[TB] FAIL busy_cnt_set_wins: got %0d expected %0d", busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'h0, busy1} !== exp_v) begin failures++; $display("[TB] FAIL busy1_set_wins: got %0d expected %0d", busy1, exp_v); end
    endtask

    task automatic test_bypass();
        // r9 gets an old value and a pending producer in the same cycle.
        we = 1'b1; wa = 5'd9; wd = 32'h11111111; iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        idle(); a1 = 5'd9;
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
`ifdef REGFILE_SB_BYPASS_EN
        exp_q.push_back(32'hA5A5A5A5);
`else
        exp_q.push_back(32'h11111111);
`endif
        exp_q.push_back(32'd0); exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'd2);
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin failures++; $display("[TB] FAIL bypass_same_cycle_rd1: got %h expected %h", rd1, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'h0, busy1} !== exp_v) begin failures++; $display("[TB] FAIL bypass_busy1: got %0d expected %0d", busy1, exp_v); end
        tick();
        idle();
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin failures++; $display("[TB] FAIL bypass_after_edge_rd1: got %h expected %h", rd1, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({26'h0, busy_cnt} !== exp_v) begin failures++; $display("[TB] FAIL bypass_busy_cnt: got %0d expected %0d", busy_cnt, exp_v); end
    endtask

    task automatic test_flush();
        // r3 and r7 are already busy, so issuing r1..r4 brings the count to 5.
        for (int r = 1; r <= 4; r++) begin
            iss_valid = 1'b1; iss_addr = AW'(r);
            tick();
        end
        idle();
        exp_q.push_back(32'd5);
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if ({26'h0, busy_cnt} !== exp_v) begin failures++; $display("[TB] FAIL flush_pre_cnt: got %0d expected %0d", busy_cnt, exp_v); end
        flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd6;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        tick();
        idle(); a1 = 5'd6;
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if ({26'h0, busy_cnt} !== exp_v) begin failures++; $display("[TB] FAIL flush_cnt: got %0d expected %0d", busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'h0, busy1} !== exp_v) begin failures++; $display("[TB] FAIL flush_r6_busy: got %0d expected %0d", busy1, exp_v); end
    endtask

    task automatic test_async_reset();
        iss_valid = 1'b1; iss_addr = 5'd2;
        tick();
        idle();
        // Reset asserts mid-cycle with a write to r5 pending; it must be discarded.
        a1 = 5'd5; a2 = 5'd9; dbg_sel = 5'd9;
        we = 1'b1; wa = 5'd5; wd = 32'h5555AAAA;
        #2 rst_n = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin failures++; $display("[TB] FAIL async_rd1: got %h expected %h", rd1, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rd2 !== exp_v) begin failures++; $display("[TB] FAIL async_rd2: got %h expected %h", rd2, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (dbg_data !== exp_v) begin failures++; $display("[TB] FAIL async_dbg: got %h expected %h", dbg_data, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({26'h0, busy_cnt} !== exp_v) begin failures++; $display("[TB] FAIL async_busy_cnt: got %0d expected %0d", busy_cnt, exp_v); end
        exp_q.push_back(32'h0);
        tick();
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if (dbg_data !== exp_v) begin failures++; $display("[TB] FAIL held_reset_dbg: got %h expected %h", dbg_data, exp_v); end
        rst_n = 1'b1;
        we = 1'b1; wa = 5'd9; wd = 32'hCAFEF00D;
        exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'h0);
        tick();
        idle();
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if (dbg_data !== exp_v) begin failures++; $display("[TB] FAIL first_write_after_reset: got %h expected %h", dbg_data, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rd1 !== exp_v) begin failures++; $display("[TB] FAIL r5_stays_clear: got %h expected %h", rd1, exp_v); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_busy();
        test_bypass();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
